// File: rtl/mod23_word_accumulator_pkg.sv
// Shared constants and FSM state type for the mod-23 residue datapath.
package mod23_word_accumulator_pkg;

  localparam int MODULUS     = 23;
  localparam int R_W         = 5;
  localparam int WORD_MUL_64 = 6;   // 2^64 mod MODULUS
  localparam int MAX_WORDS   = 16;
  localparam int CNT_W       = 5;
  localparam int SUM_W       = 8;   // holds 22*6+31 = 163

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/mod23_mac_reduce.sv
// Combinational multiply-accumulate with modular reduction:
// res = (acc * WORD_MUL + r) mod MODULUS, no divider.
module mod23_mac_reduce
  import mod23_word_accumulator_pkg::*;
#(
  parameter int MOD_VAL  = MODULUS,
  parameter int RES_W    = R_W,
  parameter int MUL_VAL  = WORD_MUL_64,
  parameter int SUM_WID  = SUM_W
) (
  input  logic [RES_W-1:0] acc,
  input  logic [RES_W-1:0] r,
  output logic [RES_W-1:0] res
);

  localparam logic [SUM_WID-1:0] MUL_C = SUM_WID'(MUL_VAL);
  localparam logic [SUM_WID-1:0] M1    = SUM_WID'(MOD_VAL);
  localparam logic [SUM_WID-1:0] M2    = SUM_WID'(2 * MOD_VAL);
  localparam logic [SUM_WID-1:0] M4    = SUM_WID'(4 * MOD_VAL);

  logic [SUM_WID-1:0] s0, s1, s2, s3;

  // Product+sum, then three conditional subtractions (4M, 2M, M) narrow 0..163 to 0..M-1.
  always_comb begin
    s0  = SUM_WID'(acc) * MUL_C + SUM_WID'(r);
    s1  = (s0 >= M4) ? s0 - M4 : s0;
    s2  = (s1 >= M2) ? s1 - M2 : s1;
    s3  = (s2 >= M1) ? s2 - M1 : s2;
    res = RES_W'(s3);
  end

endmodule

// File: rtl/mod23_word_accumulator.sv
// Folds a MSW-first stream of per-word mod-23 residues into the residue of a
// multi-word operand and presents it on a valid/ready handshake.
module mod23_word_accumulator
  import mod23_word_accumulator_pkg::*;
#(
  parameter int MODULUS_P   = MODULUS,
  parameter int R_W_P       = R_W,
  parameter int WORD_MUL    = WORD_MUL_64,
  parameter int MAX_WORDS_P = MAX_WORDS,
  parameter int CNT_W_P     = CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               res_valid,
  input  logic [R_W_P-1:0]   res_in,
  input  logic               res_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [R_W_P-1:0]   acc_r,
  output logic [CNT_W_P-1:0] word_cnt,
  output logic               err_ovr,
  output logic               err_len,
  output logic               err_res
);

  localparam logic [R_W_P-1:0]   MOD_C = R_W_P'(MODULUS_P);
  localparam logic [CNT_W_P-1:0] MAX_C = CNT_W_P'(MAX_WORDS_P);

  acc_state_t         state, state_nx;
  logic [R_W_P-1:0]   mac_acc, mac_out, acc_nx;
  logic [CNT_W_P-1:0] cnt_nx;
  logic               valid_nx, ovr_set, len_set, res_set;

  // IDLE starts a fresh operand, so the shared MAC sees a zero accumulator there.
  assign mac_acc = (state == IDLE) ? '0 : acc_r;

  mod23_mac_reduce #(
    .MOD_VAL (MODULUS_P),
    .RES_W   (R_W_P),
    .MUL_VAL (WORD_MUL),
    .SUM_WID (SUM_W)
  ) u_mac (
    .acc (mac_acc),
    .r   (res_in),
    .res (mac_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state, accumulator/counter updates and error detection.
  always_comb begin
    state_nx = state;
    acc_nx   = acc_r;
    cnt_nx   = word_cnt;
    valid_nx = out_valid;
    ovr_set  = 1'b0;
    len_set  = 1'b0;
    res_set  = res_valid && (res_in >= MOD_C);
    unique case (state)
      IDLE: begin
        if (res_valid) begin
          acc_nx = mac_out;
          cnt_nx = CNT_W_P'(1);
          if (res_last) begin
            valid_nx = 1'b1;
            state_nx = HOLD;
          end else begin
            state_nx = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (res_valid) begin
          if (!res_last && (word_cnt == MAX_C)) begin
            // Over-length: drop this beat, publish what has been folded so far.
            len_set  = 1'b1;
            valid_nx = 1'b1;
            state_nx = HOLD;
          end else begin
            acc_nx = mac_out;
            cnt_nx = word_cnt + CNT_W_P'(1);
            if (res_last) begin
              valid_nx = 1'b1;
              state_nx = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (res_valid) ovr_set = 1'b1;
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output, counter and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      err_ovr   <= 1'b0;
      err_len   <= 1'b0;
      err_res   <= 1'b0;
    end else begin
      acc_r     <= acc_nx;
      word_cnt  <= cnt_nx;
      out_valid <= valid_nx;
      err_ovr   <= err_ovr | ovr_set;
      err_len   <= err_len | len_set;
      err_res   <= err_res | res_set;
    end
  end

endmodule

// File: tb/tb_mod23_word_accumulator.sv
// Self-checking bench: directed cases plus random multi-word operands checked
// against a big-integer residue model built from powers of two.
module tb_mod23_word_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       res_valid = 1'b0;
  logic [4:0] res_in = '0;
  logic       res_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] acc_r;
  logic [4:0] word_cnt;
  logic       err_ovr, err_len, err_res;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod23_word_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_in    (res_in),
    .res_last  (res_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_r     (acc_r),
    .word_cnt  (word_cnt),
    .err_ovr   (err_ovr),
    .err_len   (err_len),
    .err_res   (err_res)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Residue of sum(w[i] * 2^(64*(n-1-i))) mod 23, powers built by repeated doubling.
  function automatic int ref_residue(input int w[16], input int n);
    int total_r = 0;
    for (int i = 0; i < n; i++) begin
      int p = 1;
      repeat (64 * (n - 1 - i)) p = (p * 2) % 23;
      total_r = (total_r + w[i] * p) % 23;
    end
    return total_r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int r, input bit last);
    res_valid = 1'b1;
    res_in    = 5'(r);
    res_last  = last;
    step();
    res_valid = 1'b0;
    res_last  = 1'b0;
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_released"}, int'(out_valid), 0);
  endtask

  initial begin
    int w[16];
    int n, exp_r;

    // Reset state
    #12;
    check_eq("rst_acc",   int'(acc_r), 0);
    check_eq("rst_cnt",   int'(word_cnt), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_errs",  int'({err_ovr, err_len, err_res}), 0);
    rst_n = 1'b1;
    step();

    // 1: single word
    beat(8, 1'b1);
    check_eq("t1_valid", int'(out_valid), 1);
    check_eq("t1_acc",   int'(acc_r), 8);
    check_eq("t1_cnt",   int'(word_cnt), 1);
    accept("t1");

    // 2: 2^64 -> 6
    beat(1, 1'b0);
    check_eq("t2_mid_valid", int'(out_valid), 0);
    beat(0, 1'b1);
    check_eq("t2_acc", int'(acc_r), 6);
    check_eq("t2_cnt", int'(word_cnt), 2);
    accept("t2");

    // 3: three words of 22 with idle gaps
    beat(22, 1'b0);
    repeat (2) step();
    beat(22, 1'b0);
    check_eq("t3_mid_acc", int'(acc_r), 16);
    check_eq("t3_mid_cnt", int'(word_cnt), 2);
    repeat (2) step();
    check_eq("t3_gap_acc", int'(acc_r), 16);
    beat(22, 1'b1);
    check_eq("t3_valid", int'(out_valid), 1);
    check_eq("t3_acc",   int'(acc_r), 3);
    check_eq("t3_cnt",   int'(word_cnt), 3);

    // 4: backpressure with an overrun beat in HOLD
    step();
    step();
    beat(7, 1'b0);
    step();
    step();
    check_eq("t4_acc",   int'(acc_r), 3);
    check_eq("t4_cnt",   int'(word_cnt), 3);
    check_eq("t4_valid", int'(out_valid), 1);
    check_eq("t4_ovr",   int'(err_ovr), 1);
    // overrun in the same cycle as out_ready is still dropped
    res_valid = 1'b1; res_in = 5'd9; res_last = 1'b1;
    accept("t4");
    res_valid = 1'b0; res_last = 1'b0;
    step();
    check_eq("t4_idle_valid", int'(out_valid), 0);
    check_eq("t4_idle_acc",   int'(acc_r), 3);

    // 5: 17 beats without last
    for (int i = 0; i < 16; i++) w[i] = $urandom_range(22, 0);
    exp_r = ref_residue(w, 16);
    for (int i = 0; i < 16; i++) beat(w[i], 1'b0);
    check_eq("t5_pre_valid", int'(out_valid), 0);
    check_eq("t5_pre_len",   int'(err_len), 0);
    beat(int'($urandom_range(22, 0)), 1'b0);
    check_eq("t5_len",   int'(err_len), 1);
    check_eq("t5_valid", int'(out_valid), 1);
    check_eq("t5_acc",   int'(acc_r), exp_r);
    check_eq("t5_cnt",   int'(word_cnt), 16);
    accept("t5");

    // Illegal residue is flagged but still folded
    beat(30, 1'b1);
    check_eq("res_flag", int'(err_res), 1);
    check_eq("res_acc",  int'(acc_r), 30 % 23);
    accept("res");

    // 6: asynchronous reset mid-ACCUM
    beat(4, 1'b0);
    beat(9, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_acc",   int'(acc_r), 0);
    check_eq("t6_cnt",   int'(word_cnt), 0);
    check_eq("t6_valid", int'(out_valid), 0);
    check_eq("t6_errs",  int'({err_ovr, err_len, err_res}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    beat(5, 1'b1);
    check_eq("t6_acc_new", int'(acc_r), 5);
    check_eq("t6_cnt_new", int'(word_cnt), 1);
    accept("t6");

    // Random operands against the reference model
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(16, 1);
      for (int i = 0; i < n; i++) w[i] = $urandom_range(22, 0);
      exp_r = ref_residue(w, n);
      for (int i = 0; i < n; i++) begin
        beat(w[i], i == n - 1);
        if (i != n - 1) repeat ($urandom_range(2, 0)) step();
      end
      check_eq("rnd_valid", int'(out_valid), 1);
      check_eq("rnd_acc",   int'(acc_r), exp_r);
      check_eq("rnd_cnt",   int'(word_cnt), n);
      repeat ($urandom_range(3, 0)) begin
        step();
        check_eq("rnd_hold", int'(acc_r), exp_r);
      end
      accept("rnd");
      repeat ($urandom_range(1, 0)) step();
    end
    check_eq("rnd_errs", int'({err_ovr, err_len, err_res}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
